// File: rtl/fifo_credit_pkg.sv
// fifo_credit_pkg
//   Shared defaults for the credit-based virtual-channel FIFO and a helper
//   that locates one channel's field inside the packed credit vector.
//   No ports (package).
package fifo_credit_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_VC     = 4;
   localparam int DEF_VC_DEPTH   = 8;

   // LSB of channel vc's credit field; each field is addr_w+1 bits wide so
   // it can hold the full-depth value.
   function automatic int credit_lsb(input int vc, input int addr_w);
      return vc * (addr_w + 1);
   endfunction

endpackage

// File: rtl/fifo_credit_vc_rr_arbiter.sv
// rr_arbiter
//   Round-robin selector over the non-empty virtual channels. The search
//   starts one above the last popped channel. Once an entry is presented
//   without being accepted, the grant is held until the handshake.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req           per-channel non-empty flags
//   hold          presented but not accepted this cycle (take/keep lock)
//   pop           handshake this cycle (advance round-robin, drop lock)
//   grant_valid   a grant is presented
//   grant         granted channel index
//
// state    | meaning
// ST_FREE  | no outstanding grant, search each cycle
// ST_HOLD  | grant presented and stalled, index frozen in lock_idx_q
module rr_arbiter
   import fifo_credit_pkg::*;
#(
   parameter int NUM_VC = DEF_NUM_VC,
   parameter int VC_W   = $clog2(NUM_VC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_VC-1:0] req,
   input  logic              hold,
   input  logic              pop,
   output logic              grant_valid,
   output logic [VC_W-1:0]   grant
);

   localparam logic [0:0]    ST_FREE  = 1'b0;
   localparam logic [0:0]    ST_HOLD  = 1'b1;
   localparam logic [VC_W:0] NUM_VC_L = (VC_W+1)'(NUM_VC);

   logic [0:0]      state_q;
   logic [VC_W-1:0] last_q;
   logic [VC_W-1:0] lock_idx_q;
   logic [VC_W-1:0] next_idx;
   logic [VC_W:0]   cand;
   logic            any_req;

   // Walk offsets from the far end down to 1 so the nearest requester
   // (smallest offset above last_q) is the final assignment and wins.
   always_comb begin
      next_idx = '0;
      any_req  = 1'b0;
      cand     = '0;
      for (int i = NUM_VC; i >= 1; i--) begin
         cand = {1'b0, last_q} + (VC_W+1)'(i);
         if (cand >= NUM_VC_L) cand = cand - NUM_VC_L;
         if (req[cand[VC_W-1:0]]) begin
            next_idx = cand[VC_W-1:0];
            any_req  = 1'b1;
         end
      end
   end

   assign grant_valid = (state_q == ST_HOLD) || any_req;
   assign grant       = (state_q == ST_HOLD) ? lock_idx_q : next_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_FREE;
         last_q     <= VC_W'(NUM_VC - 1);
         lock_idx_q <= '0;
      end else if (pop) begin
         state_q <= ST_FREE;
         last_q  <= grant;
      end else if (hold) begin
         state_q    <= ST_HOLD;
         lock_idx_q <= grant;
      end
   end

endmodule

// File: rtl/fifo_credit_vc.sv
// fifo_credit_vc
//   Multi-channel FIFO with per-channel credit accounting. Each virtual
//   channel owns a private circular partition of VC_DEPTH entries; a write
//   is accepted while the channel has credit, and the read side presents one
//   channel at a time chosen round-robin.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_valid/wr_vc/wr_data   write request, target channel, payload
//   wr_ready                 target channel has a free slot
//   rd_valid/rd_vc/rd_data   presented entry, its channel, its payload
//   rd_ready                 consumer accepts the presented entry
//   credit_count             free slots per channel, ADDR_W+1 bits each
//   credit_return            one-cycle pulse for each channel popped
module fifo_credit_vc
   import fifo_credit_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_VC     = DEF_NUM_VC,
   parameter int VC_DEPTH   = DEF_VC_DEPTH,
   parameter int VC_W       = $clog2(NUM_VC),
   parameter int ADDR_W     = $clog2(VC_DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   input  logic [VC_W-1:0]              wr_vc,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   output logic                         wr_ready,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic [VC_W-1:0]              rd_vc,
   output logic [NUM_VC*(ADDR_W+1)-1:0] credit_count,
   output logic [NUM_VC-1:0]            credit_return
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(VC_DEPTH);

   logic [DATA_WIDTH-1:0] mem [NUM_VC][VC_DEPTH];
   logic [ADDR_W-1:0]     wr_ptr_q [NUM_VC];
   logic [ADDR_W-1:0]     rd_ptr_q [NUM_VC];
   logic [ADDR_W:0]       count_q  [NUM_VC];

   logic [NUM_VC-1:0] nonempty;
   logic [NUM_VC-1:0] wr_hit;
   logic [NUM_VC-1:0] pop_hit;
   logic              wr_fire;
   logic              pop;
   logic              hold;
   logic              arb_valid;
   logic [VC_W-1:0]   arb_grant;

   // An out-of-range wr_vc matches no channel, so wr_ready stays low.
   always_comb begin
      nonempty = '0;
      wr_ready = 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
         nonempty[i] = (count_q[i] != '0);
         if (wr_vc == VC_W'(i) && count_q[i] != DEPTH_L) wr_ready = 1'b1;
      end
   end

   assign wr_fire = wr_valid && wr_ready;
   assign pop     = rd_valid && rd_ready;
   assign hold    = rd_valid && !rd_ready;

   always_comb begin
      wr_hit  = '0;
      pop_hit = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         wr_hit[i]  = wr_fire && (wr_vc == VC_W'(i));
         pop_hit[i] = pop && (rd_vc == VC_W'(i));
      end
   end

   // Arbitration sees only registered occupancy, so a fresh write is not
   // presentable until the following cycle.
   rr_arbiter #(
      .NUM_VC (NUM_VC),
      .VC_W   (VC_W)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (nonempty),
      .hold        (hold),
      .pop         (pop),
      .grant_valid (arb_valid),
      .grant       (arb_grant)
   );

   assign rd_valid = arb_valid;
   assign rd_vc    = arb_grant;
   assign rd_data  = mem[arb_grant][rd_ptr_q[arb_grant]];

   for (genvar g = 0; g < NUM_VC; g++) begin : g_credit
      localparam int LSB = credit_lsb(g, ADDR_W);
      assign credit_count[LSB +: ADDR_W+1] = DEPTH_L - count_q[g];
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_vc][wr_ptr_q[wr_vc]] <= wr_data;
   end

   // A simultaneous write and pop on one channel leaves its count alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_VC; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
         credit_return <= '0;
      end else begin
         for (int i = 0; i < NUM_VC; i++) begin
            if (wr_hit[i])  wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (pop_hit[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            if (wr_hit[i] && !pop_hit[i])      count_q[i] <= count_q[i] + 1'b1;
            else if (pop_hit[i] && !wr_hit[i]) count_q[i] <= count_q[i] - 1'b1;
         end
         credit_return <= pop_hit;
      end
   end

endmodule
